// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared execute-stage types for the M-extension sequencer
package pipeline_pkg;

  // funct3 encoding of the RV32M operations
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } muldiv_state_e;

  localparam int MULDIV_XLEN  = 32;
  localparam int MULDIV_CNT_W = $clog2(MULDIV_XLEN);

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one shift-add multiply or restoring divide iteration
module muldiv_step
  import pipeline_pkg::*;
#(
  parameter int XLEN = MULDIV_XLEN
) (
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   operand_i,
  input  logic              is_div_i,
  output logic [2*XLEN-1:0] acc_o
);

  logic [XLEN:0] add_sum;
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // acc holds {partial product, multiplier} for multiply and {remainder, quotient} for divide
  always_comb begin
    add_sum = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, operand_i} : '0);
    shifted = {acc_i[2*XLEN-1:XLEN], acc_i[XLEN-1]};
    diff    = shifted - {1'b0, operand_i};
    if (is_div_i) begin
      if (diff[XLEN]) begin
        acc_o = {shifted[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
      end else begin
        acc_o = {diff[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
      end
    end else begin
      acc_o = {add_sum, acc_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/ex_muldiv_seq.sv
// rtl/ex_muldiv_seq.sv - iterative RV32M multiply/divide sequencer (option: MULDIV_FAST_MUL_EN)
module ex_muldiv_seq
  import pipeline_pkg::*;
#(
  parameter int XLEN = MULDIV_XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] src_a_i,
  input  logic [XLEN-1:0] src_b_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_e     state;
  muldiv_op_e        op;
  logic [CNT_W-1:0]  cnt;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opnd;
  logic              neg_q;
  logic              neg_r;
  logic [2*XLEN-1:0] step_out;

  muldiv_op_e        op_in;
  logic              a_signed, b_signed, sign_a, sign_b;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic              div_zero, div_ovf;
  logic [XLEN-1:0]   special_res;

  muldiv_step #(.XLEN(XLEN)) u_step (
    .acc_i     (acc),
    .operand_i (opnd),
    .is_div_i  (op[2]),
    .acc_o     (step_out)
  );

  // sign fix-up and half selection on a raw unsigned product or {remainder, quotient}
  function automatic logic [XLEN-1:0] finish(input muldiv_op_e f, input logic [2*XLEN-1:0] raw,
                                             input logic nq, input logic nr);
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    prod = nq ? -raw : raw;
    quo  = nq ? -raw[XLEN-1:0] : raw[XLEN-1:0];
    rem  = nr ? -raw[2*XLEN-1:XLEN] : raw[2*XLEN-1:XLEN];
    case (f)
      OP_MUL:                       finish = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: finish = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              finish = quo;
      default:                      finish = rem;
    endcase
  endfunction

  // operand decode at issue: signedness, magnitudes and the divide special cases
  always_comb begin
    op_in    = muldiv_op_e'(funct3_i);
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (op_in)
      OP_MULH, OP_DIV, OP_REM: begin a_signed = 1'b1; b_signed = 1'b1; end
      OP_MULHSU:               a_signed = 1'b1;
      default:                 ;
    endcase
    sign_a   = a_signed & src_a_i[XLEN-1];
    sign_b   = b_signed & src_b_i[XLEN-1];
    mag_a    = sign_a ? -src_a_i : src_a_i;
    mag_b    = sign_b ? -src_b_i : src_b_i;
    div_zero = funct3_i[2] && (src_b_i == '0);
    div_ovf  = (op_in == OP_DIV || op_in == OP_REM) && (src_a_i == INT_MIN) && (src_b_i == '1);
    if (div_zero) begin
      special_res = (op_in == OP_DIV || op_in == OP_DIVU) ? '1 : src_a_i;
    end else if (div_ovf) begin
      special_res = (op_in == OP_DIV) ? INT_MIN : '0;
    end else begin
      special_res = '0;
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  assign fast_prod = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
`endif

  // the instruction is held in EX from the issue cycle through the last iteration
  assign stall_o = rst_n & ~flush_i & (((state == S_IDLE) & valid_i) | (state == S_CALC));

  // sequencer: issue, iterate, present the registered result for one cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      op       <= OP_MUL;
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      done_o   <= 1'b0;
      result_o <= '0;
    end else if (flush_i) begin
      state  <= S_IDLE;
      cnt    <= '0;
      done_o <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done_o <= 1'b0;
          if (valid_i) begin
            op    <= op_in;
            neg_q <= sign_a ^ sign_b;
            neg_r <= sign_a;
            acc   <= {{XLEN{1'b0}}, mag_a};
            opnd  <= mag_b;
            cnt   <= CNT_W'(XLEN-1);
            if (div_zero || div_ovf) begin
              result_o <= special_res;
              done_o   <= 1'b1;
              state    <= S_DONE;
`ifdef MULDIV_FAST_MUL_EN
            end else if (!funct3_i[2]) begin
              result_o <= finish(op_in, fast_prod, sign_a ^ sign_b, sign_a);
              done_o   <= 1'b1;
              state    <= S_DONE;
`endif
            end else begin
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          acc <= step_out;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            result_o <= finish(op, step_out, neg_q, neg_r);
            done_o   <= 1'b1;
            state    <= S_DONE;
          end
        end
        default: begin
          done_o <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// tb/tb_ex_muldiv_seq.sv - directed table-driven bench for ex_muldiv_seq
module tb_ex_muldiv_seq;
  localparam int XLEN = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MLAT = 1;
`else
  localparam int MLAT = XLEN + 1;
`endif
  localparam int DLAT = XLEN + 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            valid_i = 1'b0;
  logic            flush_i = 1'b0;
  logic [2:0]      funct3_i = 3'b000;
  logic [XLEN-1:0] src_a_i = '0;
  logic [XLEN-1:0] src_b_i = '0;
  logic            stall_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ex_muldiv_seq #(.XLEN(XLEN)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid_i  (valid_i),
    .funct3_i (funct3_i),
    .src_a_i  (src_a_i),
    .src_b_i  (src_b_i),
    .flush_i  (flush_i),
    .stall_o  (stall_o),
    .done_o   (done_o),
    .result_o (result_o)
  );

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    string       name;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // issue one op on the next falling edge; cycle 0 is the issue cycle
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int stalls, output int dcyc);
    @(negedge clk);
    valid_i  = 1'b1;
    funct3_i = f;
    src_a_i  = a;
    src_b_i  = b;
    #1;
    stalls = 0;
    dcyc   = -1;
    res    = 'x;
    for (int c = 0; c < 100; c++) begin
      if (stall_o) stalls++;
      if (done_o) begin
        dcyc = c;
        res  = result_o;
        break;
      end
      @(negedge clk);
      #1;
    end
    if (dcyc < 0) begin
      errors++;
      checks++;
      $display("FAIL timeout waiting for done_o funct3=%b", f);
    end
  endtask

  initial begin
    logic [31:0] r1, r2;
    int s1, s2, d1, d2, t1, t2, done_seen;

    vecs[0]  = '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MLAT, "mul_7x-3"};
    vecs[1]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MLAT, "mulhu_max"};
    vecs[2]  = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MLAT, "mulhsu_max"};
    vecs[3]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MLAT, "mulh_min_min"};
    vecs[4]  = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, MLAT, "mulh_m1_m1"};
    vecs[5]  = '{3'b000, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, MLAT, "mul_wrap"};
    vecs[6]  = '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, DLAT, "div_-7/2"};
    vecs[7]  = '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, DLAT, "rem_-7/2"};
    vecs[8]  = '{3'b101, 32'd100,       32'd7,         32'd14,        DLAT, "divu_100/7"};
    vecs[9]  = '{3'b111, 32'd100,       32'd7,         32'd2,         DLAT, "remu_100/7"};
    vecs[10] = '{3'b100, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, DLAT, "div_7/-2"};
    vecs[11] = '{3'b110, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, DLAT, "rem_7/-2"};
    vecs[12] = '{3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1,    "divu_5/0"};
    vecs[13] = '{3'b110, 32'd5,         32'd0,         32'd5,         1,    "rem_5/0"};
    vecs[14] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,    "div_ovf"};
    vecs[15] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1,    "rem_ovf"};

    repeat (2) @(negedge clk);
    #1;
    chk("reset_stall", {31'd0, stall_o}, 32'd0);
    chk("reset_done", {31'd0, done_o}, 32'd0);
    chk("reset_result", result_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      run_op(vecs[i].f, vecs[i].a, vecs[i].b, r1, s1, d1);
      chk($sformatf("%s_result", vecs[i].name), r1, vecs[i].exp);
      chk($sformatf("%s_done_cycle", vecs[i].name), d1, vecs[i].lat);
      chk($sformatf("%s_stall_cycles", vecs[i].name), s1, vecs[i].lat);
      @(negedge clk);
      valid_i = 1'b0;
    end

    // back-to-back divides: the second issues in the cycle right after the first DONE
    run_op(3'b100, 32'd20, 32'd4, r1, s1, d1);
    t1 = cyc;
    run_op(3'b100, 32'd9, 32'd3, r2, s2, d2);
    t2 = cyc;
    chk("b2b_first_result", r1, 32'd5);
    chk("b2b_second_result", r2, 32'd3);
    chk("b2b_second_done_cycle", d2, DLAT);
    chk("b2b_done_spacing", t2 - t1, DLAT + 1);
    @(negedge clk);
    valid_i = 1'b0;

    // flush at CALC step 10
    @(negedge clk);
    valid_i  = 1'b1;
    funct3_i = 3'b101;
    src_a_i  = 32'd100;
    src_b_i  = 32'd7;
    repeat (10) @(negedge clk);
    flush_i = 1'b1;
    #1;
    chk("flush_stall_same_cycle", {31'd0, stall_o}, 32'd0);
    @(negedge clk);
    flush_i = 1'b0;
    valid_i = 1'b0;
    #1;
    chk("flush_stall_next", {31'd0, stall_o}, 32'd0);
    done_seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (done_o) done_seen++;
      @(negedge clk);
      #1;
    end
    chk("flush_no_done", done_seen, 0);

    // reset in the middle of CALC, with valid still held
    @(negedge clk);
    valid_i  = 1'b1;
    funct3_i = 3'b000;
    src_a_i  = 32'd3;
    src_b_i  = 32'd5;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midreset_stall", {31'd0, stall_o}, 32'd0);
    chk("midreset_done", {31'd0, done_o}, 32'd0);
    chk("midreset_result", result_o, 32'd0);
    @(negedge clk);
    rst_n   = 1'b1;
    valid_i = 1'b0;

    run_op(3'b011, 32'h8000_0000, 32'd2, r1, s1, d1);
    chk("post_reset_mulhu", r1, 32'd1);
    chk("post_reset_mulhu_done_cycle", d1, MLAT);
    @(negedge clk);
    valid_i = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
